// File: rtl/vin_pattern_gen.sv
// Internal video test-pattern source: vsync/hsync/de raster plus two
// 8-bit pixels per clock, matching the FPD-Link receiver video contract.
// Ports: clk, rst (sync, active-high), enable, pattern_sel[1:0] in;
//        v_pclk, v_vsync, v_hsync, v_de, v_pixel[15:0], frame_cnt[7:0] out.
module vin_pattern_gen #(
    parameter int H_FP   = 32,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 152,
    parameter int H_ACT  = 800,
    parameter int V_FP   = 1,
    parameter int V_SYNC = 3,
    parameter int V_BP   = 46,
    parameter int V_ACT  = 1200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        v_pclk,
    output logic        v_vsync,
    output logic        v_hsync,
    output logic        v_de,
    output logic [15:0] v_pixel,
    output logic [7:0]  frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

    localparam logic [11:0] H_SE   = 12'(H_SYNC);
    localparam logic [11:0] H_A0   = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_A1   = 12'(H_SYNC + H_BP + H_ACT);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_SE   = 12'(V_SYNC);
    localparam logic [11:0] V_A0   = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_A1   = 12'(V_SYNC + V_BP + V_ACT);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // Only the low bits of the active offsets feed the pattern logic.
    localparam logic [9:0] C0 = H_A0[9:0];
    localparam logic [7:0] Y0 = V_A0[7:0];

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [1:0]  pat;

    logic        h_sync;
    logic        v_sync;
    logic        de;
    logic [9:0]  c;
    logic [7:0]  y;
    logic [15:0] pix;

    assign v_pclk = clk;

    always_comb begin
        h_sync = (h_cnt < H_SE);
        v_sync = (v_cnt < V_SE);
        de     = (h_cnt >= H_A0) && (h_cnt < H_A1) &&
                 (v_cnt >= V_A0) && (v_cnt < V_A1);
        c      = h_cnt[9:0] - C0;
        y      = v_cnt[7:0] - Y0;
        pix    = 16'h0000;
        if (de) begin
            case (pat)
                2'd0: pix = {c[6:0], 1'b1, c[6:0], 1'b0};
                2'd1: pix = {y, y};
                2'd2: pix = {16{c[2] ^ y[3]}};
                default: pix = (c[9:3] == frame_cnt[6:0]) ? 16'h0000
                                                          : 16'hFFFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            pat       <= '0;
            frame_cnt <= '0;
            v_vsync   <= 1'b0;
            v_hsync   <= 1'b0;
            v_de      <= 1'b0;
            v_pixel   <= '0;
        end else if (!enable) begin
            // Abort the frame; frame_cnt and pat are kept.
            h_cnt   <= '0;
            v_cnt   <= '0;
            v_vsync <= 1'b0;
            v_hsync <= 1'b0;
            v_de    <= 1'b0;
            v_pixel <= '0;
        end else begin
            v_vsync <= v_sync;
            v_hsync <= h_sync;
            v_de    <= de;
            v_pixel <= pix;
            // Pattern changes only at frame start so a frame never tears.
            if (h_cnt == '0 && v_cnt == '0) begin
                pat <= pattern_sel;
            end
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt     <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    v_cnt <= v_cnt + 12'd1;
                end
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_vin_pattern_gen.sv
// Bench for vin_pattern_gen: two small rasters checked every clock
// against a position-based reference model, plus directed raster checks.
module tb_vin_pattern_gen;

    typedef struct {
        int hs, hb, ha, hf, vs, vb, va, vf;
    } geo_t;

    typedef struct {
        int         pos;
        logic [1:0] pat;
        logic [7:0] fc;
    } mst_t;

    typedef struct {
        logic        vs, hs, de;
        logic [15:0] px;
        logic [7:0]  fc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, pclk_a, vs_a, hs_a, de_a;
    logic [1:0]  sel_a;
    logic [15:0] px_a;
    logic [7:0]  fc_a;
    logic        rst_b, en_b, pclk_b, vs_b, hs_b, de_b;
    logic [1:0]  sel_b;
    logic [15:0] px_b;
    logic [7:0]  fc_b;

    vin_pattern_gen #(
        .H_FP(2), .H_SYNC(2), .H_BP(2), .H_ACT(4),
        .V_FP(1), .V_SYNC(1), .V_BP(1), .V_ACT(2)
    ) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .pattern_sel(sel_a),
        .v_pclk(pclk_a), .v_vsync(vs_a), .v_hsync(hs_a), .v_de(de_a),
        .v_pixel(px_a), .frame_cnt(fc_a)
    );

    vin_pattern_gen #(
        .H_FP(2), .H_SYNC(2), .H_BP(2), .H_ACT(32),
        .V_FP(1), .V_SYNC(1), .V_BP(1), .V_ACT(9)
    ) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .pattern_sel(sel_b),
        .v_pclk(pclk_b), .v_vsync(vs_b), .v_hsync(hs_b), .v_de(de_b),
        .v_pixel(px_b), .frame_cnt(fc_b)
    );

    geo_t ga, gb;
    mst_t st [2];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   cyc_a  = 0;
    int   cyc_b  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_tot++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // Reference: a frame is a flat run of positions; h/v come from
    // division, pixels straight from the pattern formulas.
    task automatic model(input int id, input geo_t g, input logic r,
                         input logic e, input logic [1:0] sel,
                         output exp_t x);
        int ht, f, h, v, c, y;
        x = '{vs: 1'b0, hs: 1'b0, de: 1'b0, px: 16'h0, fc: 8'h0};
        ht = g.hs + g.hb + g.ha + g.hf;
        f  = ht * (g.vs + g.vb + g.va + g.vf);
        if (r) begin
            st[id].pos = 0;
            st[id].pat = 2'd0;
            st[id].fc  = 8'd0;
        end else if (!e) begin
            st[id].pos = 0;
        end else begin
            h = st[id].pos % ht;
            v = st[id].pos / ht;
            if (st[id].pos == 0) st[id].pat = sel;
            c = h - (g.hs + g.hb);
            y = v - (g.vs + g.vb);
            x.hs = (h < g.hs);
            x.vs = (v < g.vs);
            x.de = (c >= 0) && (c < g.ha) && (y >= 0) && (y < g.va);
            if (x.de) begin
                case (st[id].pat)
                    2'd0: x.px = {8'(2 * c + 1), 8'(2 * c)};
                    2'd1: x.px = {8'(y), 8'(y)};
                    2'd2: x.px = (((c / 4) % 2) != ((y / 8) % 2))
                                 ? 16'hFFFF : 16'h0000;
                    default: x.px = (((c / 8) % 128) == (st[id].fc % 128))
                                    ? 16'h0000 : 16'hFFFF;
                endcase
            end
            if (st[id].pos == f - 1) st[id].fc = st[id].fc + 8'd1;
            st[id].pos = (st[id].pos + 1) % f;
        end
        x.fc = st[id].fc;
    endtask

    task automatic tick();
        exp_t ea, eb;
        model(0, ga, rst_a, en_a, sel_a, ea);
        model(1, gb, rst_b, en_b, sel_b, eb);
        @(posedge clk);
        #1;
        chk("a_vsync", vs_a, ea.vs);
        chk("a_hsync", hs_a, ea.hs);
        chk("a_de",    de_a, ea.de);
        chk("a_pixel", px_a, ea.px);
        chk("a_fcnt",  fc_a, ea.fc);
        chk("b_vsync", vs_b, eb.vs);
        chk("b_hsync", hs_b, eb.hs);
        chk("b_de",    de_b, eb.de);
        chk("b_pixel", px_b, eb.px);
        chk("b_fcnt",  fc_b, eb.fc);
        cyc_a++;
        cyc_b++;
    endtask

    initial begin
        logic [15:0] grad [4];
        logic [15:0] q0 [$];
        logic [15:0] q1 [$];
        logic [15:0] cb [9][32];
        logic [15:0] bar [32];
        int hs_n, vs_n, de_n, first_de;

        ga = '{hs: 2, hb: 2, ha: 4, hf: 2, vs: 1, vb: 1, va: 2, vf: 1};
        gb = '{hs: 2, hb: 2, ha: 32, hf: 2, vs: 1, vb: 1, va: 9, vf: 1};
        grad = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 32; j++) cb[i][j] = 16'h1234;
        for (int j = 0; j < 32; j++) bar[j] = 16'h1234;
        for (int i = 0; i < 2; i++) st[i] = '{pos: 0, pat: 2'd0, fc: 8'd0};
        hs_n = 0; vs_n = 0; de_n = 0; first_de = -1;

        rst_a = 1'b1; en_a = 1'b1; sel_a = 2'd0;
        rst_b = 1'b1; en_b = 1'b1; sel_b = 2'd2;
        repeat (3) tick();
        chk("rst_vsync", vs_a, 1'b0);
        chk("rst_hsync", hs_a, 1'b0);
        chk("rst_de",    de_a, 1'b0);
        chk("rst_pixel", px_a, 16'h0);
        chk("rst_fcnt",  fc_a, 8'h0);
        chk("pclk",      pclk_a, 1'b1);

        // Raster timing, gradient and pattern latch (A); checkerboard
        // and moving bar (B, frame = 38 x 12 = 456 clocks).
        rst_a = 1'b0; rst_b = 1'b0; cyc_a = 0; cyc_b = 0;
        while (cyc_b < 1400) begin
            tick();
            if (cyc_a == 1) begin
                chk("first_vsync", vs_a, 1'b1);
                chk("first_hsync", hs_a, 1'b1);
            end
            if (cyc_a <= 150) begin
                if (hs_a) hs_n++;
                if (vs_a) vs_n++;
                if (de_a) de_n++;
                if (de_a && first_de < 0) first_de = cyc_a;
                if (de_a && cyc_a <= 50) q0.push_back(px_a);
                else if (de_a && cyc_a <= 100) q1.push_back(px_a);
                if (cyc_a % 50 == 0) chk("fcnt_step", fc_a, 8'(cyc_a / 50));
            end
            if (cyc_a == 30) sel_a = 2'd1;
            if (cyc_b == 100) sel_b = 2'd3;
            if (de_b) begin
                int p, f, h, v;
                p = cyc_b - 1;
                f = p / 456;
                h = (p % 456) % 38;
                v = (p % 456) / 38;
                if (f == 0) cb[v - 2][h - 4] = px_b;
                if (f == 2 && v == 2) bar[h - 4] = px_b;
            end
        end
        chk("hsync_count", hs_n, 30);
        chk("vsync_count", vs_n, 30);
        chk("de_count", de_n, 24);
        chk("first_de_cycle", first_de, 25);
        chk("f0_de_len", q0.size(), 8);
        chk("f1_de_len", q1.size(), 8);
        for (int i = 0; i < 8 && i < q0.size(); i++)
            chk("grad_pixel", q0[i], grad[i % 4]);
        for (int i = 0; i < 8 && i < q1.size(); i++)
            chk("latch_vgrad", q1[i], (i < 4) ? 16'h0000 : 16'h0101);
        for (int j = 0; j < 4; j++) chk("cb_y0_dark", cb[0][j], 16'h0000);
        chk("cb_y0_c4", cb[0][4], 16'hFFFF);
        chk("cb_y8_c0", cb[8][0], 16'hFFFF);
        for (int j = 0; j < 32; j++)
            chk("bar_f2", bar[j],
                (j >= 16 && j <= 23) ? 16'h0000 : 16'hFFFF);

        // Mid-frame reset at cycle 27.
        rst_a = 1'b1; tick(); rst_a = 1'b0; cyc_a = 0;
        while (cyc_a < 27) tick();
        rst_a = 1'b1;
        tick();
        chk("mrst_vsync", vs_a, 1'b0);
        chk("mrst_hsync", hs_a, 1'b0);
        chk("mrst_pixel", px_a, 16'h0);
        chk("mrst_fcnt",  fc_a, 8'h0);
        rst_a = 1'b0; cyc_a = 0;
        tick();
        chk("restart_vsync", vs_a, 1'b1);
        chk("restart_hsync", hs_a, 1'b1);

        // Enable drop at cycle 12 of the second frame.
        while (cyc_a < 62) tick();
        en_a = 1'b0;
        repeat (5) begin
            tick();
            chk("off_vsync", vs_a, 1'b0);
            chk("off_de", de_a, 1'b0);
            chk("off_pixel", px_a, 16'h0);
            chk("off_fcnt", fc_a, 8'd1);
        end
        en_a = 1'b1;
        tick();
        chk("reen_vsync", vs_a, 1'b1);
        chk("reen_hsync", hs_a, 1'b1);

        // Random pattern/enable/reset traffic against the model.
        repeat (3000) begin
            sel_a = 2'($urandom);
            sel_b = 2'($urandom);
            en_a  = ($urandom_range(0, 99) != 0);
            en_b  = ($urandom_range(0, 999) != 0);
            rst_a = ($urandom_range(0, 499) == 0);
            rst_b = ($urandom_range(0, 1999) == 0);
            tick();
        end

        // frame_cnt wrap after 256 frames.
        rst_a = 1'b1; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
        tick();
        rst_a = 1'b0;
        repeat (255 * 50) tick();
        chk("fcnt_255", fc_a, 8'd255);
        repeat (50) tick();
        chk("fcnt_wrap", fc_a, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
